bunny_game_ctrl: RTL and testbench
==================================

Name: bunny_game_ctrl

Overview:
Game controller for the whack-a-bunny game. Consumes the free-running 4-bit hole position from the upstream position counter (pos, 0..15) and latches it as the bunny's target hole at each round start. Checks player guesses against the target, keeps a BCD score and a lives count, and drives the 16-LED hole display. Sits between the position counter and the LED and 7-segment display drivers.

Parameters:
ROUND_CYCLES, 64, maximum PLAY cycles per round before a timeout miss (>=2)
FLASH_CYCLES, 8, duration in cycles of the HIT/MISS feedback states (>=1)
LIVES, 3, lives loaded at game start (1..3)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; starts a game from IDLE or GAME_OVER
pos  input  4  current hole position from upstream counter
guess_valid  input  1  single-cycle strobe; player guess present
guess  input  4  hole selected by player; qualified by guess_valid
bunny_led  output  16  hole display; one-hot of target in PLAY
score_bcd  output  8  score, two BCD digits, [7:4] tens, [3:0] ones
lives  output  2  remaining lives
hit_pulse  output  1  one-cycle pulse on a correct guess
miss_pulse  output  1  one-cycle pulse on a wrong guess or timeout
game_over  output  1  high while in GAME_OVER
state  output  3  debug: IDLE=0, PLAY=1, HIT=2, MISS=3, GAME_OVER=4

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- All outputs are registered.
- Reset values: state IDLE, bunny_led 0, score_bcd 0, lives 0, hit_pulse 0, miss_pulse 0, game_over 0. Internal target, round timer and flash counter reset to 0.
- Reset mid-game aborts immediately to the reset values. No state is retained.
- IDLE:
  - bunny_led is 0.
  - On start: score_bcd <= 0, lives <= LIVES, target <= pos sampled at that edge, round timer <= ROUND_CYCLES-1, go to PLAY.
- PLAY:
  - bunny_led = 1 << target from the first PLAY cycle onward.
  - Round timer decrements every PLAY cycle.
  - guess_valid with guess==target: go to HIT. hit_pulse is high for exactly the next cycle, and score increments at the same edge.
  - guess_valid with guess!=target: go to MISS. miss_pulse is high for the next cycle, and lives decrements at the same edge.
  - timer==0 with no guess: same outcome as a wrong guess (timeout miss). PLAY therefore lasts at most ROUND_CYCLES cycles.
  - guess_valid on the same cycle as timer==0: the guess is evaluated and the timeout is ignored.
  - start is ignored.
- Score arithmetic:
  - BCD increment. Ones digit 9 -> 0 with tens +1.
  - Saturates at 0x99; a hit at 0x99 leaves 0x99 but hit_pulse still fires.
- HIT: bunny_led = 16'hFFFF for exactly FLASH_CYCLES cycles.
- MISS:
  - bunny_led = 0 for exactly FLASH_CYCLES cycles.
  - If lives reached 0 on entry to MISS, go to GAME_OVER after the flash instead of PLAY.
- Leaving HIT or MISS toward PLAY: target <= pos sampled at the exit edge, round timer <= ROUND_CYCLES-1.
- guess_valid and start are ignored in HIT and MISS.
- Consecutive rounds may reuse the same hole when pos is unchanged. No re-sampling is done.
- GAME_OVER:
  - game_over=1, bunny_led=0, score_bcd and lives (0) are held.
  - On start: same actions as start from IDLE, and game_over drops at the same edge.
  - guess_valid is ignored.
- lives never underflows. A decrement from 0 cannot occur because 0 lives forces GAME_OVER.
- Latency summary: guess edge N -> state, score, lives and pulse updated in cycle N+1. PLAY resumes FLASH_CYCLES cycles after entering HIT or MISS.

Test Plan:
- Reset, then start with pos=5 -> state=1, bunny_led=16'h0020, lives=3, score=0x00 one cycle after start.
- In PLAY, target 5, guess=5 with guess_valid -> next cycle hit_pulse=1, score=0x01, bunny_led=FFFF for 8 cycles, then PLAY with target = pos at exit.
- Wrong guess (3 vs 5), then a second miss by timeout (no guess for 64 cycles) -> miss_pulse each time, lives 3->2->1, bunny_led=0 during each 8-cycle flash.
- Third miss -> lives=0, after 8 cycles state=4, game_over=1. Later guess_valid pulses cause no change. start -> PLAY, lives=3, score=0x00, game_over=0.
- Force 10 and then 99 consecutive hits -> score 0x09 -> 0x10 carry, saturation at 0x99 with hit_pulse still asserted.
- guess_valid=1 with correct guess on the cycle timer==0 -> HIT, not MISS. Assert rst_n=0 during HIT -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/bunny_game_ctrl.sv
// Whack-a-bunny game controller: latches the target hole from the position
// counter, scores guesses in BCD, tracks lives and drives the 16-LED hole display.
module bunny_game_ctrl #(
    parameter int ROUND_CYCLES = 64,
    parameter int FLASH_CYCLES = 8,
    parameter int LIVES        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  pos,
    input  logic        guess_valid,
    input  logic [3:0]  guess,
    output logic [15:0] bunny_led,
    output logic [7:0]  score_bcd,
    output logic [1:0]  lives,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic        game_over,
    output logic [2:0]  state
);

    localparam int TW = (ROUND_CYCLES > 2) ? $clog2(ROUND_CYCLES) : 1;
    localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_INIT = TW'(ROUND_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_INIT = FW'(FLASH_CYCLES - 1);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PLAY = 3'd1,
        S_HIT  = 3'd2,
        S_MISS = 3'd3,
        S_OVER = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    target_q, target_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] flash_q, flash_d;
    logic [7:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic [15:0]   led_q, led_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic          game_over_q, game_over_d;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        timer_d     = timer_q;
        flash_d     = flash_q;
        score_d     = score_q;
        lives_d     = lives_q;
        led_d       = led_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        game_over_d = game_over_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d     = S_PLAY;
                    score_d     = 8'h00;
                    lives_d     = LIVES_INIT;
                    target_d    = pos;
                    timer_d     = TIMER_INIT;
                    led_d       = 16'h0001 << pos;
                    game_over_d = 1'b0;
                end
            end
            S_PLAY: begin
                // A guess on the final timer cycle wins over the timeout.
                if (guess_valid && (guess == target_q)) begin
                    state_d = S_HIT;
                    hit_d   = 1'b1;
                    score_d = bcd_inc(score_q);
                    led_d   = 16'hFFFF;
                    flash_d = FLASH_INIT;
                end else if (guess_valid || (timer_q == '0)) begin
                    state_d = S_MISS;
                    miss_d  = 1'b1;
                    lives_d = lives_q - 2'd1;
                    led_d   = 16'h0000;
                    flash_d = FLASH_INIT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_HIT, S_MISS: begin
                if (flash_q == '0) begin
                    if ((state_q == S_MISS) && (lives_q == 2'd0)) begin
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                        led_d       = 16'h0000;
                    end else begin
                        state_d  = S_PLAY;
                        target_d = pos;
                        timer_d  = TIMER_INIT;
                        led_d    = 16'h0001 << pos;
                    end
                end else begin
                    flash_d = flash_q - FW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                led_d   = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            target_q    <= 4'd0;
            timer_q     <= '0;
            flash_q     <= '0;
            score_q     <= 8'h00;
            lives_q     <= 2'd0;
            led_q       <= 16'h0000;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            timer_q     <= timer_d;
            flash_q     <= flash_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            led_q       <= led_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            game_over_q <= game_over_d;
        end
    end

    assign bunny_led  = led_q;
    assign score_bcd  = score_q;
    assign lives      = lives_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign game_over  = game_over_q;
    assign state      = state_q;

endmodule

// File: tb/tb_bunny_game_ctrl.sv
// Directed bench for bunny_game_ctrl: guesses push expected hit/miss records,
// a monitor pops one per output pulse and checks score and lives.
module tb_bunny_game_ctrl;

    localparam int RC = 64;
    localparam int FC = 8;
    localparam int W  = 12;  // {hit, miss, score[7:0], lives[1:0]}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  pos = 4'd0;
    logic        guess_valid = 1'b0;
    logic [3:0]  guess = 4'd0;
    logic [15:0] bunny_led;
    logic [7:0]  score_bcd;
    logic [1:0]  lives;
    logic        hit_pulse;
    logic        miss_pulse;
    logic        game_over;
    logic [2:0]  state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model_score;
    logic [1:0] model_lives;

    bunny_game_ctrl #(.ROUND_CYCLES(RC), .FLASH_CYCLES(FC), .LIVES(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pos(pos),
        .guess_valid(guess_valid), .guess(guess), .bunny_led(bunny_led),
        .score_bcd(score_bcd), .lives(lives), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .game_over(game_over), .state(state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // monitor: every hit/miss pulse must match the oldest expected record
    always @(negedge clk) begin
        if (rst_n && (hit_pulse || miss_pulse)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: hit=%b miss=%b score=%h lives=%0d",
                         hit_pulse, miss_pulse, score_bcd, lives);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({hit_pulse, miss_pulse, score_bcd, lives} !== e) begin
                    n_fail++;
                    $display("FAIL event: got hit=%b miss=%b score=%h lives=%0d expected hit=%b miss=%b score=%h lives=%0d",
                             hit_pulse, miss_pulse, score_bcd, lives, e[11], e[10], e[9:2], e[1:0]);
                end
            end
        end
    end

    function automatic logic [7:0] bcd_next(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) r = v;
        else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // driver tasks: inputs change on the falling edge
    task automatic do_start(input logic [3:0] p);
        pos = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_score = 8'h00;
        model_lives = 2'd3;
    endtask

    task automatic do_guess(input logic [3:0] g, input logic is_hit);
        if (is_hit) model_score = bcd_next(model_score);
        else        model_lives = model_lives - 2'd1;
        exp_q.push_back({is_hit, ~is_hit, model_score, model_lives});
        guess = g;
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
    endtask

    task automatic expect_timeout();
        model_lives = model_lives - 2'd1;
        exp_q.push_back({1'b0, 1'b1, model_score, model_lives});
        @(negedge clk);
    endtask

    // Called in the first flash cycle; leaves the bench in the first PLAY cycle.
    task automatic finish_flash(input logic [2:0] flash_state, input logic [3:0] next_pos);
        repeat (FC - 1) @(negedge clk);
        check("flash_len", 16'(state), 16'(flash_state));
        pos = next_pos;
        @(negedge clk);
        check("resume_state", 16'(state), 16'd1);
        check("resume_led", bunny_led, 16'h0001 << next_pos);
    endtask

    initial begin
        model_score = 8'h00;
        model_lives = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_state", 16'(state), 16'd0);
        check("rst_led", bunny_led, 16'h0000);
        check("rst_score", 16'(score_bcd), 16'h00);
        check("rst_lives", 16'(lives), 16'd0);
        check("rst_pulses", {14'd0, hit_pulse, miss_pulse}, 16'd0);
        check("rst_game_over", 16'(game_over), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_state", 16'(state), 16'd0);

        // start with pos 5
        do_start(4'd5);
        check("start_state", 16'(state), 16'd1);
        check("start_led", bunny_led, 16'h0020);
        check("start_lives", 16'(lives), 16'd3);
        check("start_score", 16'(score_bcd), 16'h00);

        // correct guess
        do_guess(4'd5, 1'b1);
        check("hit_state", 16'(state), 16'd2);
        check("hit_led", bunny_led, 16'hFFFF);
        check("hit_score", 16'(score_bcd), 16'h01);
        guess = 4'd5; guess_valid = 1'b1;  // ignored during HIT
        @(negedge clk);
        guess_valid = 1'b0;
        check("hit_ignore_guess", 16'(state), 16'd2);
        repeat (FC - 3) @(negedge clk);
        pos = 4'd5;
        @(negedge clk);
        check("hit_last_cycle", 16'(state), 16'd2);
        @(negedge clk);
        check("resume_after_hit", bunny_led, 16'h0020);

        // wrong guess 3 vs 5
        do_guess(4'd3, 1'b0);
        check("miss_state", 16'(state), 16'd3);
        check("miss_led", bunny_led, 16'h0000);
        check("miss_lives", 16'(lives), 16'd2);
        finish_flash(3'd3, 4'd7);

        // timeout miss: PLAY lasts exactly RC cycles
        repeat (RC - 1) @(negedge clk);
        check("play_last_cycle", 16'(state), 16'd1);
        expect_timeout();
        check("timeout_state", 16'(state), 16'd3);
        check("timeout_lives", 16'(lives), 16'd1);
        check("timeout_led", bunny_led, 16'h0000);
        finish_flash(3'd3, 4'd7);

        // third miss ends the game
        do_guess(4'd2, 1'b0);
        check("last_miss_lives", 16'(lives), 16'd0);
        repeat (FC - 1) @(negedge clk);
        check("last_flash", 16'(state), 16'd3);
        @(negedge clk);
        check("over_state", 16'(state), 16'd4);
        check("over_flag", 16'(game_over), 16'd1);
        check("over_led", bunny_led, 16'h0000);
        check("over_score", 16'(score_bcd), 16'h01);
        for (int i = 0; i < 3; i++) begin
            guess = 4'(i + 6); guess_valid = 1'b1;
            @(negedge clk);
            guess_valid = 1'b0;
            @(negedge clk);
        end
        check("over_hold_state", 16'(state), 16'd4);
        check("over_hold_lives", 16'(lives), 16'd0);

        // restart from GAME_OVER
        do_start(4'd0);
        check("restart_state", 16'(state), 16'd1);
        check("restart_lives", 16'(lives), 16'd3);
        check("restart_score", 16'(score_bcd), 16'h00);
        check("restart_flag", 16'(game_over), 16'd0);
        check("restart_led", bunny_led, 16'h0001);

        // 100 hits: carry at 10, saturation at 99
        for (int i = 1; i <= 100; i++) begin
            do_guess(4'd0, 1'b1);
            if (i == 9)   check("score_9", 16'(score_bcd), 16'h09);
            if (i == 10)  check("score_10", 16'(score_bcd), 16'h10);
            if (i == 99)  check("score_99", 16'(score_bcd), 16'h99);
            if (i == 100) check("score_sat", 16'(score_bcd), 16'h99);
            repeat (FC) @(negedge clk);
        end
        check("after_hits_state", 16'(state), 16'd1);

        // correct guess on the timer==0 cycle wins
        repeat (RC - 1) @(negedge clk);
        check("timer_zero_state", 16'(state), 16'd1);
        do_guess(4'd0, 1'b1);
        check("timer_zero_hit", 16'(state), 16'd2);

        // asynchronous reset during HIT
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 16'(state), 16'd0);
        check("arst_led", bunny_led, 16'h0000);
        check("arst_score", 16'(score_bcd), 16'h00);
        check("arst_lives", 16'(lives), 16'd0);
        check("arst_flags", {13'd0, hit_pulse, miss_pulse, game_over}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 16'(state), 16'd0);

        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
